// File: rtl/phy_rx_sp_pkg.sv
// Shared definitions for the PHY serial receive lane: idle symbol and FSM states.
package phy_rx_sp_pkg;

  // Idle/comma symbol used for byte alignment and idle suppression.
  localparam logic [7:0] COM_SYM = 8'hBC;

  // Receiver lock states; encoding matches the transmit serializer.
  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    ALIGN  = 2'd1,
    ACTIVE = 2'd2
  } rx_state_e;

endpackage

// File: rtl/phy_rx_sp.sv
// Serial-to-parallel receiver: MSB-first bit stream in, COM-aligned bytes out.
// Locks on a run of LOCK_COUNT byte-spaced COMs, then presents every byte for
// 8 cycles with valid high for payload (non-COM) bytes.
module phy_rx_sp
  import phy_rx_sp_pkg::*;
#(
  parameter logic [7:0]  COM        = COM_SYM,
  parameter int unsigned LOCK_COUNT = 4
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic       data_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       active
);

  localparam logic [3:0] LOCK_N = 4'(LOCK_COUNT);

  rx_state_e  state_q, state_d;
  // Only the 7 most recent bits are needed to form the candidate byte.
  logic [6:0] sr_q, sr_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [3:0] com_cnt_q, com_cnt_d;
  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;
  logic       active_q, active_d;

  logic [7:0] cand;
  logic       is_com;
  logic       boundary;
  logic [3:0] com_inc;

  assign cand     = {sr_q, data_in};
  assign is_com   = (cand == COM);
  assign boundary = (bit_cnt_q == 3'd7);
  assign com_inc  = com_cnt_q + 4'd1;

  // Next-state: bit-slide search, byte-spaced COM counting, then byte delivery.
  always_comb begin
    state_d   = state_q;
    sr_d      = cand[6:0];
    bit_cnt_d = bit_cnt_q;
    com_cnt_d = com_cnt_q;
    data_d    = data_q;
    valid_d   = valid_q;
    active_d  = active_q;
    case (state_q)
      SEARCH: begin
        valid_d = 1'b0;
        if (is_com) begin
          bit_cnt_d = 3'd0;
          com_cnt_d = 4'd1;
          state_d   = ALIGN;
        end
      end
      ALIGN: begin
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (boundary) begin
          if (is_com) begin
            com_cnt_d = com_inc;
            // Locking boundary also loads the COM into the output register.
            if (com_inc == LOCK_N) begin
              state_d  = ACTIVE;
              active_d = 1'b1;
              data_d   = cand;
              valid_d  = 1'b0;
            end
          end else begin
            // Broken run: drop alignment and slide again from the next bit.
            com_cnt_d = 4'd0;
            state_d   = SEARCH;
          end
        end
      end
      ACTIVE: begin
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (boundary) begin
          data_d  = cand;
          valid_d = !is_com;
        end
      end
      default: begin
        state_d = SEARCH;
      end
    endcase
  end

  // All state and registered outputs; synchronous active-high reset.
  always_ff @(posedge clk_32f) begin
    if (reset) begin
      state_q   <= SEARCH;
      sr_q      <= 7'd0;
      bit_cnt_q <= 3'd0;
      com_cnt_q <= 4'd0;
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
      active_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      bit_cnt_q <= bit_cnt_d;
      com_cnt_q <= com_cnt_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      active_q  <= active_d;
    end
  end

  assign data_out  = data_q;
  assign valid_out = valid_q;
  assign active    = active_q;

endmodule

// File: tb/tb_phy_rx_sp.sv
// Bench for phy_rx_sp: directed lock/payload/reset scenarios plus random
// streams, all checked every cycle against a bit-history reference model.
module tb_phy_rx_sp;

  localparam logic [7:0] COM = 8'hBC;
  localparam int         LK  = 4;

  logic       clk_32f = 1'b0;
  logic       reset   = 1'b1;
  logic       data_in = 1'b0;
  logic [7:0] data_out;
  logic       valid_out;
  logic       active;

  int n_chk  = 0;
  int n_fail = 0;

  bit bits[$];        // bits sampled since the last reset, index 0 first
  int lock_seen;      // bit index at which active was first observed, -1 if none

  phy_rx_sp #(.COM(COM), .LOCK_COUNT(LK)) dut (
    .clk_32f  (clk_32f),
    .reset    (reset),
    .data_in  (data_in),
    .data_out (data_out),
    .valid_out(valid_out),
    .active   (active)
  );

  always #5 clk_32f = ~clk_32f;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (bit %0d)", tag, obs, exp, bits.size() - 1);
    end
  endtask

  // Byte whose last (LSB) bit is bit n; bits before reset read as zero.
  function automatic logic [7:0] byte_at(int n);
    logic [7:0] r;
    r = 8'h00;
    for (int i = 0; i < 8; i++) begin
      int idx;
      idx = n - 7 + i;
      r[7-i] = (idx >= 0) ? bits[idx] : 1'b0;
    end
    return r;
  endfunction

  // Bit index where lock is achieved within bits 0..last, or -1.
  // Lock = a COM match anywhere, followed by LK-1 further COMs at 8-bit spacing;
  // a non-COM at a spaced position restarts the search right after it.
  function automatic int lock_pos(int last);
    int s;
    s = 0;
    while (1) begin
      int p;
      bit broken;
      p = -1;
      for (int i = s; i <= last; i++)
        if (byte_at(i) == COM) begin
          p = i;
          break;
        end
      if (p < 0) return -1;
      broken = 0;
      for (int j = 1; j < LK; j++) begin
        int q;
        q = p + 8 * j;
        if (q > last) return -1;
        if (byte_at(q) != COM) begin
          s = q + 1;
          broken = 1;
          break;
        end
      end
      if (!broken) return p + 8 * (LK - 1);
    end
    return -1;
  endfunction

  task automatic check_model();
    int n, lk;
    logic [7:0] ed;
    logic ev, ea;
    n  = bits.size() - 1;
    lk = lock_pos(n);
    if (lk < 0) begin
      ed = 8'h00; ev = 1'b0; ea = 1'b0;
    end else begin
      ed = byte_at(lk + 8 * ((n - lk) / 8));
      ev = (ed != COM);
      ea = 1'b1;
    end
    chk("data_out", 32'(data_out), 32'(ed));
    chk("valid_out", 32'(valid_out), 32'(ev));
    chk("active", 32'(active), 32'(ea));
  endtask

  task automatic send_bit(input bit b);
    data_in = b;
    @(posedge clk_32f);
    bits.push_back(b);
    #1;
    if (active === 1'b1 && lock_seen < 0) lock_seen = bits.size() - 1;
    check_model();
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic do_reset(input int cyc);
    reset   = 1'b1;
    data_in = 1'b0;
    for (int i = 0; i < cyc; i++) begin
      @(posedge clk_32f);
      #1;
      chk("rst_data", 32'(data_out), 32'h0);
      chk("rst_valid", 32'(valid_out), 32'h0);
      chk("rst_active", 32'(active), 32'h0);
    end
    bits.delete();
    lock_seen = -1;
    reset = 1'b0;
  endtask

  initial begin
    lock_seen = -1;

    // Reset then idle: byte-aligned COM run locks at the 4th COM boundary.
    do_reset(2);
    repeat (4) send_byte(COM);
    chk("lock_aligned", 32'(lock_seen), 32'd31);
    chk("idle_data", 32'(data_out), 32'hBC);
    chk("idle_valid", 32'(valid_out), 32'h0);
    // Payload with an embedded COM.
    send_byte(8'h12);
    chk("pl_12", 32'(data_out), 32'h12);
    send_byte(8'h34);
    chk("pl_34", 32'(data_out), 32'h34);
    send_byte(COM);
    chk("pl_bc_valid", 32'(valid_out), 32'h0);
    send_byte(8'hFF);
    chk("pl_ff", 32'(data_out), 32'hFF);
    chk("pl_ff_valid", 32'(valid_out), 32'h1);
    repeat (6) send_byte(8'($urandom));

    // Misalignment: 3 random bits ahead of the COM run.
    do_reset(1);
    repeat (3) send_bit(1'($urandom));
    repeat (4) send_byte(COM);
    chk("lock_shifted", 32'(lock_seen), 32'd34);
    send_byte(8'hA5);
    chk("shift_a5", 32'(data_out), 32'hA5);
    repeat (5) send_byte(8'($urandom));

    // Broken run: 0x55 breaks the count, lock only at the 7th byte.
    do_reset(1);
    send_byte(COM); send_byte(COM); send_byte(8'h55);
    repeat (4) send_byte(COM);
    chk("lock_broken", 32'(lock_seen), 32'd55);
    send_byte(8'h3C);
    chk("broken_3c", 32'(data_out), 32'h3C);

    // Reset mid-payload: one reset cycle during byte 0x34, then relock.
    do_reset(1);
    repeat (4) send_byte(COM);
    send_byte(8'h12);
    for (int i = 7; i >= 5; i--) send_bit(1'((8'h34 >> i) & 8'h1));
    do_reset(1);
    for (int i = 4; i >= 0; i--) send_bit(1'((8'h34 >> i) & 8'h1));
    chk("post_rst_active", 32'(active), 32'h0);
    repeat (3) send_byte(8'($urandom));
    repeat (4) send_byte(COM);
    repeat (4) send_byte(8'($urandom));

    // Random streams: random prefix, COM-heavy byte stream with payload.
    for (int t = 0; t < 8; t++) begin
      do_reset(1 + $urandom_range(0, 1));
      repeat ($urandom_range(0, 12)) send_bit(1'($urandom));
      for (int k = 0; k < 24; k++) begin
        if ($urandom_range(0, 2) != 0) send_byte(COM);
        else send_byte(8'($urandom));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
